// File: rtl/press_charge.sv
// ============================================================================
// Module   : press_charge
// Purpose  : Jump-button front end. Synchronises and debounces the raw key,
//            charges a level on clock-divider strobes while the key is held,
//            and hands the charge to the jump stage as a valid/ready power
//            value on release.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module press_charge #(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int CHARGE_W     = 8,
    parameter int CHARGE_MAX   = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_in,
    input  logic                en,
    input  logic                charge_tick,
    output logic [CHARGE_W-1:0] power,
    output logic                power_valid,
    input  logic                power_ready,
    output logic                charging,
    output logic [CHARGE_W-1:0] charge_level
);

    // The counter only needs to reach DEBOUNCE_CYC-1; the next differing
    // cycle is the DEBOUNCE_CYC-th one and flips the debounced key.
    localparam int                 CNT_W     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CHARGE_W-1:0] LEVEL_MAX = CHARGE_W'(CHARGE_MAX);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CHARGE   = 2'd1,
        S_HOLD     = 2'd2,
        S_WAIT_REL = 2'd3
    } state_t;

    logic                sync1_q;
    logic                sync2_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                key_db_q;
    logic                key_db_prev_q;
    logic [1:0]          prime_q;
    logic                armed_q;
    state_t              state_q;
    logic [CHARGE_W-1:0] level_q;
    logic [CHARGE_W-1:0] level_d;
    logic [CHARGE_W-1:0] power_q;
    logic                power_valid_q;
    logic                key_rise;
    logic                key_fall;

    // Two-flop synchroniser for the asynchronous key input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level only after it has differed for a full run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q         <= '0;
            key_db_q      <= 1'b0;
            key_db_prev_q <= 1'b0;
        end else begin
            key_db_prev_q <= key_db_q;
            if (sync2_q == key_db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                key_db_q <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign key_rise = key_db_q & ~key_db_prev_q;
    assign key_fall = ~key_db_q & key_db_prev_q;

    // Arming: a key held through reset must be seen released before it can
    // charge, so only arm once the primed synchroniser reports a low key.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prime_q <= 2'd0;
            armed_q <= 1'b0;
        end else begin
            if (prime_q != 2'd2) begin
                prime_q <= prime_q + 2'd1;
            end
            if ((prime_q == 2'd2) && !sync2_q && !key_db_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    // A tick coincident with release is counted before the level is latched.
    assign level_d = (charge_tick && (level_q < LEVEL_MAX)) ? level_q + 1'b1 : level_q;

    // Charge/handoff state machine with registered power outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            level_q       <= '0;
            power_q       <= '0;
            power_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (key_rise) begin
                        if (en && armed_q) begin
                            state_q <= S_CHARGE;
                            level_q <= '0;
                        end else begin
                            state_q <= S_WAIT_REL;
                        end
                    end
                end
                S_CHARGE: begin
                    if (!en) begin
                        level_q <= '0;
                        state_q <= key_db_q ? S_WAIT_REL : S_IDLE;
                    end else if (key_fall) begin
                        power_q <= level_d;
                        level_q <= level_d;
                        if (level_d != '0) begin
                            power_valid_q <= 1'b1;
                            state_q       <= S_HOLD;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        level_q <= level_d;
                    end
                end
                S_HOLD: begin
                    if (power_ready) begin
                        power_valid_q <= 1'b0;
                        level_q       <= '0;
                        state_q       <= key_db_q ? S_WAIT_REL : S_IDLE;
                    end
                end
                S_WAIT_REL: begin
                    if (!key_db_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign power        = power_q;
    assign power_valid  = power_valid_q;
    assign charging     = (state_q == S_CHARGE);
    assign charge_level = level_q;

endmodule

`default_nettype wire

// File: tb/tb_press_charge.sv
// ============================================================================
// Module   : tb_press_charge
// Purpose  : Self-checking bench for press_charge with scenario tasks and a
//            tick-count reference model for the expected jump power.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_press_charge;

    localparam int DEB = 4;
    localparam int W   = 4;
    localparam int MAX = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_in;
    logic         en;
    logic         charge_tick;
    logic         power_ready;
    logic [W-1:0] power;
    logic         power_valid;
    logic         charging;
    logic [W-1:0] charge_level;

    int checks   = 0;
    int failures = 0;

    press_charge #(
        .DEBOUNCE_CYC (DEB),
        .CHARGE_W     (W),
        .CHARGE_MAX   (MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .en           (en),
        .charge_tick  (charge_tick),
        .power        (power),
        .power_valid  (power_valid),
        .power_ready  (power_ready),
        .charging     (charging),
        .charge_level (charge_level)
    );

    always #5 clk = ~clk;

    // Reference model: power is the number of counted ticks, clamped at MAX.
    function automatic int model_power(input int ticks);
        return (ticks > MAX) ? MAX : ticks;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_and_wait(input string name);
        bit seen;
        seen   = 1'b0;
        key_in = 1'b1;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            if (charging === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_start charging=%b required=1", name, charging);
        end
    endtask

    task automatic give_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            charge_tick = 1'b1;
            step();
            charge_tick = 1'b0;
            step($urandom_range(0, 2));
        end
    endtask

    // Release; optionally place one tick on the cycle the fall pulse is seen
    // (2 sync edges + DEB debounce edges after the release).
    task automatic release_with(input bit coincide);
        key_in = 1'b0;
        step(2 + DEB);
        if (coincide) charge_tick = 1'b1;
        step();
        charge_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; key_in = 1'b0; en = 1'b1; charge_tick = 1'b0; power_ready = 1'b0;
        step(3);
        checks++;
        if ({power, power_valid, charging, charge_level} !== '0) begin
            failures++;
            $display("FAIL reset_outputs actual=%h/%b/%b/%h required=0/0/0/0",
                     power, power_valid, charging, charge_level);
        end
        rst = 1'b1;
        step(5);
        checks++;
        if ({power_valid, charging, charge_level} !== '0) begin
            failures++;
            $display("FAIL post_reset_idle actual=%b/%b/%h required=0/0/0",
                     power_valid, charging, charge_level);
        end
    endtask

    task automatic test_debounce();
        int pat [8] = '{1, 1, 1, 0, 0, 1, 1, 1};
        int bad;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            key_in = pat[i][0];
            step();
            if (dut.key_db_q !== 1'b0 || charging !== 1'b0) bad++;
        end
        key_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (dut.key_db_q !== 1'b0 || charging !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL debounce_glitch bad_cycles=%0d required=0", bad);
        end
    endtask

    task automatic test_normal_jump();
        int hi;
        power_ready = 1'b1;
        press_and_wait("normal");
        give_ticks(10);
        checks++;
        if (charge_level !== 4'd10) begin
            failures++;
            $display("FAIL normal_level actual=%0d required=10", charge_level);
        end
        release_with(1'b0);
        checks++;
        if (power_valid !== 1'b1 || power !== 4'(model_power(10))) begin
            failures++;
            $display("FAIL normal_power valid=%b power=%0d required=1/%0d",
                     power_valid, power, model_power(10));
        end
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (power_valid === 1'b1) hi++;
        end
        checks++;
        if (hi != 0 || charging !== 1'b0 || charge_level !== '0) begin
            failures++;
            $display("FAIL normal_after extra_valid=%0d charging=%b level=%0d required=0/0/0",
                     hi, charging, charge_level);
        end
    endtask

    task automatic test_saturation();
        power_ready = 1'b1;
        press_and_wait("sat");
        give_ticks(20);
        checks++;
        if (charge_level !== 4'(MAX)) begin
            failures++;
            $display("FAIL sat_level actual=%0d required=%0d", charge_level, MAX);
        end
        release_with(1'b1);
        checks++;
        if (power_valid !== 1'b1 || power !== 4'(model_power(21))) begin
            failures++;
            $display("FAIL sat_power valid=%b power=%0d required=1/%0d",
                     power_valid, power, model_power(21));
        end
        step();
        checks++;
        if (power_valid !== 1'b0) begin
            failures++;
            $display("FAIL sat_valid_drop actual=%b required=0", power_valid);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        power_ready = 1'b0;
        press_and_wait("bp");
        give_ticks(7);
        release_with(1'b0);
        checks++;
        if (power_valid !== 1'b1 || power !== 4'd7) begin
            failures++;
            $display("FAIL bp_power valid=%b power=%0d required=1/7", power_valid, power);
        end
        key_in = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (power_valid !== 1'b1 || power !== 4'd7 || charging !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold bad_cycles=%0d required=0", bad);
        end
        power_ready = 1'b1;
        step();
        power_ready = 1'b0;
        checks++;
        if (power_valid !== 1'b0 || charge_level !== '0) begin
            failures++;
            $display("FAIL bp_accept valid=%b level=%0d required=0/0", power_valid, charge_level);
        end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (charging !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_held_no_restart charging_cycles=%0d required=0", bad);
        end
        key_in = 1'b0;
        step(10);
        press_and_wait("bp_restart");
        release_with(1'b0);
        step();
        checks++;
        if (power_valid !== 1'b0 || charging !== 1'b0) begin
            failures++;
            $display("FAIL bp_zero_release valid=%b charging=%b required=0/0",
                     power_valid, charging);
        end
    endtask

    task automatic test_abort();
        int bad;
        power_ready = 1'b1;
        press_and_wait("abort");
        give_ticks(6);
        checks++;
        if (charge_level !== 4'd6) begin
            failures++;
            $display("FAIL abort_level actual=%0d required=6", charge_level);
        end
        en = 1'b0;
        step();
        en = 1'b1;
        checks++;
        if (charge_level !== '0 || charging !== 1'b0 || power_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_clear level=%0d charging=%b valid=%b required=0/0/0",
                     charge_level, charging, power_valid);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (charging !== 1'b0 || power_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL abort_wait_rel bad_cycles=%0d required=0", bad);
        end
        key_in = 1'b0;
        step(10);
        press_and_wait("abort_restart");
        release_with(1'b0);
        step();
    endtask

    task automatic test_reset_mid_charge();
        int bad;
        power_ready = 1'b0;
        press_and_wait("rst");
        give_ticks(9);
        checks++;
        if (charge_level !== 4'd9) begin
            failures++;
            $display("FAIL rst_level actual=%0d required=9", charge_level);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({power, power_valid, charging, charge_level} !== '0) begin
            failures++;
            $display("FAIL rst_async actual=%h/%b/%b/%h required=0/0/0/0",
                     power, power_valid, charging, charge_level);
        end
        step(2);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (charging !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rst_held_key charging_cycles=%0d required=0", bad);
        end
        key_in = 1'b0;
        step(10);
        press_and_wait("rst_restart");
        release_with(1'b0);
        step();
    endtask

    task automatic test_random_jumps();
        int n, co, dly, exp_p, bad;
        for (int it = 0; it < 8; it++) begin
            n   = $urandom_range(0, 20);
            co  = $urandom_range(0, 1);
            dly = $urandom_range(0, 4);
            power_ready = 1'b0;
            press_and_wait("rand");
            give_ticks(n);
            checks++;
            if (charge_level !== 4'(model_power(n))) begin
                failures++;
                $display("FAIL rand_level it=%0d actual=%0d required=%0d",
                         it, charge_level, model_power(n));
            end
            release_with(co[0]);
            exp_p = model_power(n + co);
            if (exp_p == 0) begin
                checks++;
                if (power_valid !== 1'b0 || charging !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_zero it=%0d valid=%b charging=%b required=0/0",
                             it, power_valid, charging);
                end
            end else begin
                bad = 0;
                if (power_valid !== 1'b1 || power !== 4'(exp_p)) bad++;
                for (int d = 0; d < dly; d++) begin
                    step();
                    if (power_valid !== 1'b1 || power !== 4'(exp_p)) bad++;
                end
                checks++;
                if (bad != 0) begin
                    failures++;
                    $display("FAIL rand_power it=%0d valid=%b power=%0d required=1/%0d",
                             it, power_valid, power, exp_p);
                end
                power_ready = 1'b1;
                step();
                power_ready = 1'b0;
                checks++;
                if (power_valid !== 1'b0 || charge_level !== '0) begin
                    failures++;
                    $display("FAIL rand_accept it=%0d valid=%b level=%0d required=0/0",
                             it, power_valid, charge_level);
                end
            end
            step(2);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_normal_jump();
        test_saturation();
        test_backpressure();
        test_abort();
        test_reset_mid_charge();
        test_random_jumps();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
